// File: rtl/parking_timer_if.sv
// Button, tick and session-status signals of the parking session timer.
// The master side drives the buttons and the 1 Hz tick; the slave side is the timer.
interface parking_timer_if;
   logic        tick_1hz;
   logic        btn_start;
   logic        btn_stop;
   logic        btn_clear;
   logic [11:0] sec_count;
   logic        running;
   logic        stopped;
   logic        saturated;
   logic        session_end;

   modport master (
      output tick_1hz, btn_start, btn_stop, btn_clear,
      input  sec_count, running, stopped, saturated, session_end
   );

   modport slave (
      input  tick_1hz, btn_start, btn_stop, btn_clear,
      output sec_count, running, stopped, saturated, session_end
   );
endinterface

// File: rtl/parking_timer.sv
// Parking session timer: counts 1 Hz ticks between start and stop button
// presses, saturating at MAX_SEC, and freezes the count at session end so
// the downstream cost stage stays stable until the user clears.
module parking_timer #(
   parameter int unsigned MAX_SEC = 4095
) (
   input  logic            clk,
   input  logic            rst,
   parking_timer_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, RUNNING, STOPPED} state_t;

   localparam logic [11:0] MAX_COUNT = 12'(MAX_SEC);

   // Button order in the vectors below: bit 0 start, bit 1 stop, bit 2 clear.
   localparam int BTN_START = 0;
   localparam int BTN_STOP  = 1;
   localparam int BTN_CLEAR = 2;

   state_t      state_reg, state_next;
   logic [11:0] count_reg, count_next;
   logic        sat_reg, sat_next;
   logic        end_reg, end_next;
   logic [2:0]  prev_reg;
   logic [2:0]  btn_level;
   logic [2:0]  btn_edge;

   assign btn_level = {bus.btn_clear, bus.btn_stop, bus.btn_start};

   // Rising-edge detect per button; prev resets high so a button held
   // through reset only counts after it is released and pressed again.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_edge
         assign btn_edge[gi] = btn_level[gi] & ~prev_reg[gi];
      end
   endgenerate

   // State, count and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         count_reg <= 12'd0;
         sat_reg   <= 1'b0;
         end_reg   <= 1'b0;
         prev_reg  <= 3'b111;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         sat_reg   <= sat_next;
         end_reg   <= end_next;
         prev_reg  <= btn_level;
      end
   end

   // Next-state logic: clear beats stop beats tick while running; clear beats
   // start when stopped; ticks never move a frozen count.
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      sat_next   = sat_reg;
      end_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            count_next = 12'd0;
            if (btn_edge[BTN_START]) begin
               state_next = RUNNING;
               sat_next   = 1'b0;
            end
         end
         RUNNING: begin
            if (btn_edge[BTN_CLEAR]) begin
               state_next = IDLE;
               count_next = 12'd0;
            end else if (btn_edge[BTN_STOP]) begin
               state_next = STOPPED;
               end_next   = 1'b1;
            end else if (bus.tick_1hz) begin
               if (count_reg < MAX_COUNT) begin
                  count_next = count_reg + 12'd1;
                  if ((count_reg + 12'd1) == MAX_COUNT) begin
                     sat_next = 1'b1;
                  end
               end else begin
                  sat_next = 1'b1;
               end
            end
         end
         STOPPED: begin
            if (btn_edge[BTN_CLEAR]) begin
               state_next = IDLE;
               count_next = 12'd0;
               sat_next   = 1'b0;
            end else if (btn_edge[BTN_START]) begin
               state_next = RUNNING;
               count_next = 12'd0;
               sat_next   = 1'b0;
            end
         end
         default: begin
            state_next = IDLE;
            count_next = 12'd0;
            sat_next   = 1'b0;
         end
      endcase
   end

   assign bus.sec_count   = count_reg;
   assign bus.running     = (state_reg == RUNNING);
   assign bus.stopped     = (state_reg == STOPPED);
   assign bus.saturated   = sat_reg;
   assign bus.session_end = end_reg;
endmodule

// File: tb/tb_parking_timer.sv
// Scoreboarded bench for parking_timer: every driven cycle pushes the
// reference model's expected outputs; a monitor pops and compares them.
module tb_parking_timer;
   localparam int MAX_SEC = 150;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   parking_timer_if bus();

   parking_timer #(.MAX_SEC(MAX_SEC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [11:0] cnt;
      logic        run;
      logic        stp;
      logic        sat;
      logic        send;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: session mode 0 idle, 1 running, 2 stopped.
   int m_mode  = 0;
   int m_count = 0;
   bit m_sat   = 0;
   bit m_end   = 0;
   bit p_start = 1, p_stop = 1, p_clear = 1;

   task automatic model_step(input bit r, input bit s, input bit p, input bit c, input bit t);
      bit se, pe, ce;
      se = s && !p_start;
      pe = p && !p_stop;
      ce = c && !p_clear;
      p_start = s; p_stop = p; p_clear = c;
      m_end = 0;
      if (r) begin
         m_mode = 0; m_count = 0; m_sat = 0;
         p_start = 1; p_stop = 1; p_clear = 1;
      end else if (m_mode == 0) begin
         if (se) begin m_mode = 1; m_count = 0; m_sat = 0; end
      end else if (m_mode == 1) begin
         if (ce) begin
            m_mode = 0; m_count = 0;
         end else if (pe) begin
            m_mode = 2; m_end = 1;
         end else if (t) begin
            m_count = (m_count + 1 > MAX_SEC) ? MAX_SEC : m_count + 1;
            if (m_count == MAX_SEC) m_sat = 1;
         end
      end else begin
         if (ce) begin
            m_mode = 0; m_count = 0; m_sat = 0;
         end else if (se) begin
            m_mode = 1; m_count = 0; m_sat = 0;
         end
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the next edge.
   task automatic cycle(input bit r, input bit s, input bit p, input bit c, input bit t);
      exp_t e;
      @(negedge clk);
      rst           = r;
      bus.btn_start = s;
      bus.btn_stop  = p;
      bus.btn_clear = c;
      bus.tick_1hz  = t;
      model_step(r, s, p, c, t);
      e.cnt  = 12'(m_count);
      e.run  = (m_mode == 1);
      e.stp  = (m_mode == 2);
      e.sat  = m_sat;
      e.send = m_end;
      q.push_back(e);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 1);
   endtask

   // Direct check of a spec-derived constant, sampled after the pending edge.
   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: compare DUT outputs with the scoreboard every cycle.
   initial begin
      exp_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            a = {bus.sec_count, bus.running, bus.stopped, bus.saturated, bus.session_end};
            n_cmp++;
            if (a !== e || (bus.running && bus.stopped)) begin
               n_bad++;
               $display("FAIL outputs @%0t: got cnt=%0d run=%b stp=%b sat=%b end=%b, required cnt=%0d run=%b stp=%b sat=%b end=%b",
                        $time, a.cnt, a.run, a.stp, a.sat, a.send, e.cnt, e.run, e.stp, e.sat, e.send);
            end
         end
      end
   end

   initial begin
      bit s, p, c;
      bus.btn_start = 1'b0; bus.btn_stop = 1'b0; bus.btn_clear = 1'b0; bus.tick_1hz = 1'b0;

      // Start held through reset: no session until released and pressed again.
      for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 1);
      settle();
      chk("reset_hold_running", int'(bus.running), 0);
      chk("reset_hold_count", int'(bus.sec_count), 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      settle();
      chk("press_after_release_running", int'(bus.running), 1);
      $display("transaction: reset hold done");

      // Basic session: 125 ticks then stop.
      cycle(0, 0, 0, 0, 0);
      ticks(125);
      cycle(0, 0, 1, 0, 0);
      settle();
      chk("basic_count", int'(bus.sec_count), 125);
      chk("basic_stopped", int'(bus.stopped), 1);
      chk("basic_session_end", int'(bus.session_end), 1);
      cycle(0, 0, 0, 0, 1);
      settle();
      chk("basic_session_end_drop", int'(bus.session_end), 0);
      ticks(5);
      settle();
      chk("basic_frozen", int'(bus.sec_count), 125);
      $display("transaction: basic session done");

      // Stop and tick in the same cycle: tick discarded.
      cycle(0, 1, 0, 0, 0);
      ticks(10);
      cycle(0, 0, 1, 0, 1);
      settle();
      chk("stop_tick_count", int'(bus.sec_count), 10);
      chk("stop_tick_stopped", int'(bus.stopped), 1);
      $display("transaction: stop with tick done");

      // Restart from STOPPED at count 7.
      cycle(0, 1, 0, 0, 0);
      ticks(7);
      cycle(0, 0, 1, 0, 0);
      cycle(0, 1, 0, 0, 0);
      settle();
      chk("restart_running", int'(bus.running), 1);
      chk("restart_count", int'(bus.sec_count), 0);

      // Clear and start together from STOPPED: clear wins.
      ticks(3);
      cycle(0, 0, 1, 0, 0);
      cycle(0, 1, 0, 1, 0);
      settle();
      chk("clear_start_running", int'(bus.running), 0);
      chk("clear_start_stopped", int'(bus.stopped), 0);
      chk("clear_start_count", int'(bus.sec_count), 0);
      $display("transaction: restart and clear done");

      // Saturation at MAX_SEC with extra ticks.
      cycle(0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      ticks(MAX_SEC - 1);
      settle();
      chk("pre_sat_flag", int'(bus.saturated), 0);
      ticks(1);
      settle();
      chk("sat_flag", int'(bus.saturated), 1);
      ticks(10);
      settle();
      chk("sat_count", int'(bus.sec_count), MAX_SEC);
      $display("transaction: saturation done");

      // Mid-session clear at 42.
      cycle(0, 0, 0, 1, 0);
      cycle(0, 1, 0, 0, 0);
      ticks(42);
      cycle(0, 0, 0, 1, 0);
      settle();
      chk("abort_running", int'(bus.running), 0);
      chk("abort_count", int'(bus.sec_count), 0);
      chk("abort_session_end", int'(bus.session_end), 0);

      // Reset mid-session.
      cycle(0, 1, 0, 0, 0);
      ticks(5);
      cycle(1, 0, 0, 0, 1);
      settle();
      chk("rst_outputs", int'({bus.sec_count, bus.running, bus.stopped, bus.saturated, bus.session_end}), 0);
      $display("transaction: abort and reset done");

      // Randomized traffic against the model.
      s = 0; p = 0; c = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0)   s = ~s;
         if ($urandom_range(0, 15) == 0)  p = ~p;
         if ($urandom_range(0, 40) == 0)  c = ~c;
         cycle(($urandom_range(0, 499) == 0), s, p, c, ($urandom_range(0, 2) != 0));
      end
      $display("transaction: random traffic done");

      cycle(0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/parking_timer.md
# parking_timer

Session timer for the parking meter. It turns debounced start/stop/clear buttons and a 1 Hz enable into the elapsed-seconds count (`sec_count`, 12 bits). That count feeds the cost-conversion stage, which rounds it up to whole minutes and applies the location/hour rate. The count is frozen at session end so the downstream cost and display remain stable until the user clears.

## Interface
- `MAX_SEC`, default 4095: saturation value of `sec_count`. Must be ≤ 4095.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `tick_1hz` in 1: one-`clk`-cycle pulse, once per second.
- `btn_start` in 1: start button level. Debounced and synchronous to `clk`.
- `btn_stop` in 1: stop button level. Debounced and synchronous to `clk`.
- `btn_clear` in 1: clear button level. Debounced and synchronous to `clk`.
- `sec_count` out 12: elapsed seconds of the current or last session.
- `running` out 1: high while in RUNNING.
- `stopped` out 1: high while in STOPPED (count frozen, valid for billing).
- `saturated` out 1: high once `sec_count` has reached `MAX_SEC` in this session.
- `session_end` out 1: one-cycle pulse on the RUNNING→STOPPED transition.

## Operation
- **Edge detect:**
  - Each button has a previous-sample register. Edge = level & ~prev.
  - The prev registers reset to 1, so a button held through reset gives no edge until it is released and pressed again.
- **States:** IDLE, RUNNING, STOPPED. Encoding is free.
- **IDLE:**
  - `sec_count`=0.
  - start edge → RUNNING; `sec_count` stays 0 and `saturated` is cleared.
  - stop and clear edges have no effect.
- **RUNNING:**
  - Priority: clear > stop > tick. start edges are ignored.
  - clear edge → IDLE, `sec_count`←0, no `session_end`.
  - stop edge → STOPPED, `session_end`=1 for one cycle. A tick in the same cycle is discarded (no increment).
  - Otherwise on `tick_1hz`:
    - if `sec_count` < `MAX_SEC`: `sec_count`←`sec_count`+1;
    - else hold at `MAX_SEC`.
    - `saturated`←1 in the cycle `sec_count` becomes `MAX_SEC`.
- **STOPPED:**
  - `sec_count` and `saturated` are frozen. `tick_1hz` is ignored.
  - clear edge → IDLE, `sec_count`←0, `saturated`←0.
  - start edge (without clear) → RUNNING with `sec_count`←0 and `saturated`←0, i.e. a new session.
  - clear and start edges in the same cycle → IDLE (clear wins).
  - stop edges are ignored.
- **Arithmetic:** 12-bit unsigned. `sec_count` never wraps; it saturates.
- **Reset:** `rst` high in any state, including mid-session, forces:
  - state IDLE;
  - `sec_count`=0, `running`=0, `stopped`=0, `saturated`=0, `session_end`=0;
  - button prev registers = 1.

## Timing
- All outputs are registered. Each changes only at a rising `clk` edge.
- Button response: a level first sampled high at edge k (prev low) updates the state, `running`/`stopped` and `sec_count` after edge k. Latency is one cycle from input change.
- Tick response: `tick_1hz` high at edge k gives the incremented `sec_count` visible after edge k.
- `session_end`:
  - high for exactly the one cycle following the edge that enters STOPPED;
  - low at all other times, including after reset.
- `running` and `stopped` are never both high. Both are low in IDLE.
- The downstream cost stage is combinational on `sec_count`. Cost is valid one cycle after `session_end` rises, and stays stable while `stopped`=1.

## Test plan
- **Reset hold:**
  - Stimulus: `btn_start` held high through `rst` deassertion.
  - Required: stay IDLE, `sec_count`=0.
  - Then release `btn_start` and press it: `running`=1 one cycle later.
- **Basic session:**
  - Stimulus: start, 125 ticks, stop.
  - Required: `sec_count`=125, `stopped`=1, `session_end` pulses exactly one cycle.
  - Further ticks leave `sec_count` at 125.
- **Simultaneous stop and tick:**
  - Stimulus: 10 ticks, then a stop edge and a tick in the same cycle.
  - Required: `sec_count`=10, state STOPPED.
- **Saturation** (`MAX_SEC`=4095, or a reduced parameter, e.g. 20):
  - Stimulus: 25 ticks with `MAX_SEC`=20.
  - Required: `sec_count`=20, `saturated`=1 from the 20th tick onward, no wrap.
- **Restart and clear from STOPPED:**
  - Start edge from STOPPED at count 7: RUNNING with `sec_count`=0.
  - Clear and start edges in the same cycle: IDLE, `sec_count`=0.
- **Mid-session abort:**
  - `btn_clear` edge at count 42 in RUNNING: IDLE, `sec_count`=0, no `session_end`.
  - `rst` pulse mid-session: all outputs 0, IDLE.
